// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: time-multiplexed sequencer for the 4-2-1 neuron accelerator.
// Evaluates hidden N1, hidden N2 and output N3 on one shared combinational
// multiply-accumulate/clip datapath. It also owns the weight/bias register file.
module neuron_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int SHIFT  = 7,
  parameter int CLIP   = 127
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              valid,
  output logic              ready,
  input  logic [DATA_W-1:0] X1,
  input  logic [DATA_W-1:0] X2,
  input  logic [DATA_W-1:0] X3,
  input  logic [DATA_W-1:0] X4,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] Y,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
  output logic              busy,
  output logic [15:0]       inf_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1A,
    ST_L1B,
    ST_L2,
    ST_OUT
  } state_t;

  // Power-on weight sets, in the order N1 W1-W4, N2 W1-W4, N3 W1-W4.
  localparam logic signed [DATA_W-1:0] DEF_WT [12] = '{
    DATA_W'(-115), DATA_W'(1),   DATA_W'(-105), DATA_W'(16),
    DATA_W'(103),  DATA_W'(-22), DATA_W'(32),   DATA_W'(-56),
    DATA_W'(75),   DATA_W'(-85), DATA_W'(-38),  DATA_W'(92)
  };
  localparam logic signed [15:0] DEF_BIAS [3] = '{
    16'(12571), 16'(-8139), 16'(10182)
  };

  localparam logic signed [ACC_W-1:0] LP_HI = ACC_W'(CLIP);
  localparam logic signed [ACC_W-1:0] LP_LO = ACC_W'(-CLIP);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_ready;
  logic                      r_valid_out;
  logic                      r_busy;
  logic [15:0]               r_count;

  logic signed [DATA_W-1:0]  r_wt   [12];
  logic signed [15:0]        r_bias [3];

  logic signed [DATA_W-1:0]  r_x [4];
  logic signed [DATA_W-1:0]  r_s1;
  logic signed [DATA_W-1:0]  r_s2;
  logic signed [DATA_W-1:0]  r_y;

  logic signed [DATA_W-1:0]   w_a    [4];
  logic signed [DATA_W-1:0]   w_w    [4];
  logic signed [15:0]         w_bias;
  logic signed [2*DATA_W-1:0] w_prod [4];
  logic signed [ACC_W-1:0]    w_acc;
  logic signed [ACC_W-1:0]    w_shr;
  logic signed [DATA_W-1:0]   w_res;
  logic                       w_cfg_ok;

  assign ready     = r_ready;
  assign valid_out = r_valid_out;
  assign busy      = r_busy;
  assign Y         = r_y;
  assign inf_count = r_count;

  assign w_cfg_ok  = cfg_we && (r_state == ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: fixed three compute steps, then wait for downstream.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (valid) w_state_nxt = ST_L1A;
      ST_L1A:  w_state_nxt = ST_L1B;
      ST_L1B:  w_state_nxt = ST_L2;
      ST_L2:   w_state_nxt = ST_OUT;
      ST_OUT:  if (ready_out) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state, so they carry no
  // combinational path from any input.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ready     <= 1'b1;
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ready     <= (w_state_nxt == ST_IDLE);
      r_valid_out <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Weight/bias register file; writable only while idle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < 12; i++) r_wt[i] <= DEF_WT[i];
      for (int unsigned i = 0; i < 3; i++)  r_bias[i] <= DEF_BIAS[i];
    end else if (w_cfg_ok) begin
      case (cfg_addr)
        4'd0, 4'd1, 4'd2, 4'd3:     r_wt[cfg_addr]         <= cfg_data[DATA_W-1:0];
        4'd4:                       r_bias[0]              <= cfg_data;
        4'd5, 4'd6, 4'd7, 4'd8:     r_wt[cfg_addr - 4'd1]  <= cfg_data[DATA_W-1:0];
        4'd9:                       r_bias[1]              <= cfg_data;
        4'd10, 4'd11, 4'd12, 4'd13: r_wt[cfg_addr - 4'd2]  <= cfg_data[DATA_W-1:0];
        4'd14:                      r_bias[2]              <= cfg_data;
        default: ;
      endcase
    end
  end

  // Input vector register, captured on the accept edge only.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < 4; i++) r_x[i] <= '0;
    end else if ((r_state == ST_IDLE) && valid) begin
      r_x[0] <= X1;
      r_x[1] <= X2;
      r_x[2] <= X3;
      r_x[3] <= X4;
    end
  end

  // Operand selection for the shared datapath; output layer is the default.
  always_comb begin
    w_a[0] = r_s1;
    w_a[1] = r_s2;
    w_a[2] = '0;
    w_a[3] = '0;
    for (int unsigned i = 0; i < 4; i++) w_w[i] = r_wt[8 + i];
    w_bias = r_bias[2];
    case (r_state)
      ST_L1A: begin
        for (int unsigned i = 0; i < 4; i++) begin
          w_a[i] = r_x[i];
          w_w[i] = r_wt[i];
        end
        w_bias = r_bias[0];
      end
      ST_L1B: begin
        for (int unsigned i = 0; i < 4; i++) begin
          w_a[i] = r_x[i];
          w_w[i] = r_wt[4 + i];
        end
        w_bias = r_bias[1];
      end
      default: ;
    endcase
  end

  // Multiply-accumulate at full accumulator width, floor shift, saturate.
  always_comb begin
    w_acc = ACC_W'(w_bias);
    for (int unsigned i = 0; i < 4; i++) begin
      w_prod[i] = w_a[i] * w_w[i];
      w_acc     = w_acc + ACC_W'(w_prod[i]);
    end
    w_shr = w_acc >>> SHIFT;
    if (w_shr > LP_HI)      w_res = LP_HI[DATA_W-1:0];
    else if (w_shr < LP_LO) w_res = LP_LO[DATA_W-1:0];
    else                    w_res = w_shr[DATA_W-1:0];
  end

  // Per-step result capture: S1, S2, then the output register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_y  <= '0;
    end else begin
      case (r_state)
        ST_L1A:  r_s1 <= w_res;
        ST_L1B:  r_s2 <= w_res;
        ST_L2:   r_y  <= w_res;
        default: ;
      endcase
    end
  end

  // Completed output transfers, free-running wrap.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                               r_count <= '0;
    else if ((r_state == ST_OUT) && ready_out) r_count <= r_count + 16'd1;
  end

endmodule
